spi_rx_word_framer: RTL and testbench

//  Write-side producer for the SPI slave CDC FIFO. Oversamples SCLK/CS_N/MOSI in
//  the wclk domain, deserialises MSB-first bits into DATA_WIDTH words, pushes each

---
 rtl/spi_slave_pkg.sv | 22 ++
 rtl/spi_bit_sync.sv | 22 ++
 rtl/spi_rx_word_framer.sv | 128 ++++++++++++
 tb/tb_spi_rx_word_framer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave receive path.
package spi_slave_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PUSH   = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input spi_mode_t mode);
    return mode.cpol == mode.cpha;
  endfunction

endpackage

// File: rtl/spi_bit_sync.sv
// Multi-flop synchroniser for one asynchronous pin; reset level is a parameter.
module spi_bit_sync
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {SYNC_STAGES{RST_VAL}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rx_word_framer.sv
// SPI slave deserialiser feeding the CDC FIFO write port.
// Define SPI_RX_PARTIAL_FLUSH_EN to push a partial word (right-aligned) when cs_n rises mid-word.
module spi_rx_word_framer
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  fifo_wfull,
  output logic                  fifo_winc,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  ovf_clr,
  output logic                  rx_overflow,
  output logic                  frame_err,
  output logic                  frame_active,
  output logic [CNT_WIDTH-1:0]  rx_word_cnt
);

  localparam int unsigned     BCW      = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_prev_q;
  logic sample;
  spi_mode_t mode;

  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  winc_q, winc_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  ferr_q, ferr_d;

  spi_bit_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk_i(wclk), .rst_ni(wrst_n), .d_i(spi_sclk), .q_o(sclk_s));
  spi_bit_sync #(.RST_VAL(1'b1)) u_sync_cs_n (.clk_i(wclk), .rst_ni(wrst_n), .d_i(spi_cs_n), .q_o(cs_n_s));
  spi_bit_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk_i(wclk), .rst_ni(wrst_n), .d_i(spi_mosi), .q_o(mosi_s));

  assign mode   = {cfg_cpol, cfg_cpha};
  assign sample = sample_on_rise(mode) ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      winc_q      <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      winc_q      <= winc_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    winc_d    = 1'b0;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    // Clear first so a same-cycle set below takes priority.
    ovf_d     = ovf_q & ~ovf_clr;
    ferr_d    = ferr_q & ~ovf_clr;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        sr_d      = '0;
        if (!cs_n_s) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (cs_n_s) begin
          state_d = IDLE;
          if (bit_cnt_q != '0) begin
            ferr_d = 1'b1;
`ifdef SPI_RX_PARTIAL_FLUSH_EN
            state_d = PUSH;
`endif
          end
        end else if (sample) begin
          sr_d      = {sr_q[DATA_WIDTH-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PUSH;
        end
      end
      PUSH: begin
        if (!fifo_wfull) begin
          winc_d  = 1'b1;
          wdata_d = sr_q;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        bit_cnt_d = '0;
        sr_d      = '0;
        state_d   = cs_n_s ? IDLE : ACTIVE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_winc    = winc_q;
  assign fifo_wdata   = wdata_q;
  assign rx_overflow  = ovf_q;
  assign frame_err    = ferr_q;
  assign frame_active = (state_q == ACTIVE) || (state_q == PUSH);
  assign rx_word_cnt  = cnt_q;

endmodule

// File: tb/tb_spi_rx_word_framer.sv
// Bench for spi_rx_word_framer: directed table, hand-written reset sequence, randomized frames vs model.
`timescale 1ns/1ps
module tb_spi_rx_word_framer;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int HALF = 50;
`ifdef SPI_RX_PARTIAL_FLUSH_EN
  localparam bit FLUSH_BUILD = 1'b1;
`else
  localparam bit FLUSH_BUILD = 1'b0;
`endif

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          spi_sclk, spi_cs_n, spi_mosi;
  logic          cfg_cpol, cfg_cpha;
  logic          fifo_wfull;
  logic          fifo_winc;
  logic [DW-1:0] fifo_wdata;
  logic          ovf_clr;
  logic          rx_overflow, frame_err, frame_active;
  logic [CW-1:0] rx_word_cnt;

  spi_rx_word_framer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .fifo_wfull(fifo_wfull), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
    .ovf_clr(ovf_clr), .rx_overflow(rx_overflow), .frame_err(frame_err),
    .frame_active(frame_active), .rx_word_cnt(rx_word_cnt)
  );

  always #5 wclk = ~wclk;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  bit            tx_bits[$];
  bit            tx_full[$];
  int            exp_cnt = 0;
  bit            exp_ovf, exp_ferr;
  bit            prev_winc = 1'b0;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] bits;
    int          nbits;
    logic [1:0]  full;
    logic [31:0] exp_w0;
    int          exp_n;
    bit          exp_ovf;
    bit          exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture every write strobe; a strobe must never last two cycles.
  always @(negedge wclk) begin
    if (fifo_winc) begin
      check("winc_single_cycle", 64'(prev_winc), 64'd0);
      got_q.push_back(fifo_wdata);
    end
    prev_winc <= fifo_winc;
  end

  task automatic add_word(input logic [DW-1:0] w, input int nb, input bit full);
    for (int i = nb - 1; i >= 0; i--) begin
      tx_bits.push_back(w[i]);
      tx_full.push_back(full);
    end
  endtask

  // Reference: a full word is stored unless FIFO full; a short tail is a framing error
  // and is stored right-aligned only in the flush build.
  task automatic model_word(input logic [DW-1:0] w, input int nb, input bit full);
    if (nb < DW) exp_ferr = 1'b1;
    if (nb == DW || FLUSH_BUILD) begin
      if (full) exp_ovf = 1'b1;
      else begin
        exp_q.push_back(w);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
    end
  endtask

  task automatic send_bits(input logic [1:0] mode);
    @(negedge wclk);
    cfg_cpol = mode[1];
    cfg_cpha = mode[0];
    spi_sclk = mode[1];
    #(HALF);
    spi_cs_n = 1'b0;
    #(HALF);
    foreach (tx_bits[i]) begin
      fifo_wfull = tx_full[i];
      if (!cfg_cpha) begin
        spi_mosi = tx_bits[i];
        #(HALF); spi_sclk = ~spi_sclk;
        #(HALF); spi_sclk = ~spi_sclk;
      end else begin
        spi_sclk = ~spi_sclk;
        spi_mosi = tx_bits[i];
        #(HALF); spi_sclk = ~spi_sclk;
        #(HALF);
      end
    end
  endtask

  task automatic close_frame();
    #(HALF);
    spi_cs_n = 1'b1;
    #(2 * HALF);
    fifo_wfull = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    repeat (20) @(negedge wclk);
    check($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    if (exp_q.size() > 0) check($sformatf("%s_wdata_held", tag), 64'(fifo_wdata), 64'(exp_q[$]));
    check($sformatf("%s_overflow", tag), 64'(rx_overflow), 64'(exp_ovf));
    check($sformatf("%s_frame_err", tag), 64'(frame_err), 64'(exp_ferr));
    check($sformatf("%s_cnt", tag), 64'(rx_word_cnt), 64'(exp_cnt));
    check($sformatf("%s_active_off", tag), 64'(frame_active), 64'd0);
    ovf_clr = 1'b1;
    @(negedge wclk);
    ovf_clr = 1'b0;
    @(negedge wclk);
    check($sformatf("%s_ovf_clr", tag), 64'({rx_overflow, frame_err}), 64'd0);
    got_q.delete(); exp_q.delete(); tx_bits.delete(); tx_full.delete();
    exp_ovf = 1'b0; exp_ferr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd0, 64'hDEADBEEF, 32, 2'b00, 32'hDEADBEEF, 1, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 64'hA5A55A5A, 32, 2'b00, 32'hA5A55A5A, 1, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 64'hA5A55A5A, 32, 2'b00, 32'hA5A55A5A, 1, 1'b0, 1'b0};
    vecs[3] = '{2'd3, 64'hA5A55A5A, 32, 2'b00, 32'hA5A55A5A, 1, 1'b0, 1'b0};
    vecs[4] = '{2'd0, 64'h11111111_22222222, 64, 2'b10, 32'h11111111, 1, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 64'hABC, 12, 2'b00, FLUSH_BUILD ? 32'h00000ABC : 32'h0,
                FLUSH_BUILD ? 1 : 0, 1'b0, 1'b1};

    wrst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; fifo_wfull = 1'b0; ovf_clr = 1'b0;
    exp_ovf = 1'b0; exp_ferr = 1'b0;
    repeat (4) @(negedge wclk);
    check("reset_outputs", 64'({fifo_winc, fifo_wdata, rx_overflow, frame_err, frame_active, rx_word_cnt}), 64'd0);
    wrst_n = 1'b1;
    repeat (4) @(negedge wclk);

    foreach (vecs[v]) begin
      for (int i = vecs[v].nbits - 1; i >= 0; i--) begin
        tx_bits.push_back(vecs[v].bits[i]);
        tx_full.push_back(vecs[v].full[(vecs[v].nbits - 1 - i) / DW]);
      end
      if (vecs[v].exp_n > 0) exp_q.push_back(vecs[v].exp_w0);
      exp_cnt  = (exp_cnt + vecs[v].exp_n) % (1 << CW);
      exp_ovf  = vecs[v].exp_ovf;
      exp_ferr = vecs[v].exp_ferr;
      send_bits(vecs[v].mode);
      check($sformatf("vec%0d_active_on", v), 64'(frame_active), 64'd1);
      close_frame();
      check_frame($sformatf("vec%0d", v));
    end

    // Reset in the middle of a frame drops the partial word and everything else.
    add_word(32'hFFFFF, 20, 1'b0);
    send_bits(2'd0);
    check("midrst_active_on", 64'(frame_active), 64'd1);
    wrst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({fifo_winc, fifo_wdata, rx_overflow, frame_err, frame_active, rx_word_cnt}), 64'd0);
    spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (3) @(negedge wclk);
    wrst_n = 1'b1;
    check("midrst_no_winc", 64'(got_q.size()), 64'd0);
    got_q.delete(); tx_bits.delete(); tx_full.delete();
    exp_cnt = 0;
    add_word(32'h12345678, DW, 1'b0);
    model_word(32'h12345678, DW, 1'b0);
    send_bits(2'd0);
    close_frame();
    check_frame("after_rst");

    // Randomized frames; counter width 4 so wrap-around is crossed many times.
    for (int f = 0; f < 24; f++) begin
      logic [1:0]    mode;
      int            nw, tail;
      logic [DW-1:0] w;
      bit            full;
      mode = 2'($urandom_range(0, 3));
      nw   = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        w    = $urandom;
        full = ($urandom_range(0, 3) == 0);
        add_word(w, DW, full);
        model_word(w, DW, full);
      end
      tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW - 1) : 0;
      if (tail > 0) begin
        w    = $urandom & ((32'h1 << tail) - 1);
        full = ($urandom_range(0, 3) == 0);
        add_word(w, tail, full);
        model_word(w, tail, full);
      end
      send_bits(mode);
      close_frame();
      check_frame($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
